// File: rtl/note_meter.sv
// Recovers a square wave's half-period in clk cycles, publishing it once STABLE consecutive intervals agree.
// Outputs are registered one cycle after the triggering edge or timeout; note == 0 means silence.
module note_meter #(
    parameter int DW     = 16,
    parameter int TMAX   = 65536,
    parameter int STABLE = 2,
    parameter int TOL    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tone_in,
    output logic [DW-1:0] note,
    output logic          note_valid,
    output logic          locked
);
    localparam int CW = $clog2(TMAX) + 1;
    localparam int XW = (CW > DW) ? CW : DW;
    localparam int MW = $clog2(STABLE + 1);

    localparam logic [1:0] SILENT = 2'd0;
    localparam logic [1:0] ARM    = 2'd1;
    localparam logic [1:0] TRACK  = 2'd2;

    localparam logic [CW-1:0] CNT_MAX  = CW'(TMAX);
    localparam logic [XW-1:0] NOTE_MAX = XW'({DW{1'b1}});
    localparam logic [XW-1:0] TOL_X    = XW'(TOL);
    localparam logic [MW-1:0] STABLE_M = MW'(STABLE);

    logic          sync1_q, sync2_q, prev_q;
    logic          edge_det;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] cand_q, cand_d;
    logic [MW-1:0] match_q, match_d;
    logic [DW-1:0] note_q, note_d;
    logic          locked_q, locked_d;
    logic          note_valid_q, note_valid_d;
    logic [XW-1:0] interval_x, cand_x, diff_x;
    logic          oversize, timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            state_q      <= SILENT;
            cand_q       <= '0;
            match_q      <= '0;
            note_q       <= '0;
            locked_q     <= 1'b0;
            note_valid_q <= 1'b0;
        end else begin
            sync1_q      <= tone_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            note_q       <= note_d;
            locked_q     <= locked_d;
            note_valid_q <= note_valid_d;
        end
    end

    assign edge_det   = sync2_q ^ prev_q;
    assign interval_x = XW'(cnt_q);
    assign cand_x     = XW'(cand_q);
    assign diff_x     = (interval_x >= cand_x) ? (interval_x - cand_x) : (cand_x - interval_x);
    // An interval of 2^DW cannot be represented as a note, so it behaves like a timeout.
    assign oversize   = (interval_x > NOTE_MAX);
    assign timeout    = !edge_det && (cnt_q == CNT_MAX) && (state_q != SILENT);

    always_comb begin
        if (edge_det) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        note_d   = note_q;
        locked_d = locked_q;
        if (edge_det) begin
            if (state_q == SILENT || oversize) begin
                state_d  = ARM;
                cand_d   = '0;
                match_d  = '0;
                note_d   = '0;
                locked_d = 1'b0;
            end else begin
                state_d = TRACK;
                if (state_q == TRACK && diff_x <= TOL_X) begin
                    if (match_q != STABLE_M) begin
                        match_d = match_q + MW'(1);
                    end
                end else begin
                    cand_d  = DW'(cnt_q);
                    match_d = MW'(1);
                end
                // Once stable, every agreeing interval refreshes the note with the latest value.
                if (match_d == STABLE_M) begin
                    note_d   = DW'(cnt_q);
                    locked_d = 1'b1;
                end
            end
        end else if (timeout) begin
            state_d  = SILENT;
            cand_d   = '0;
            match_d  = '0;
            note_d   = '0;
            locked_d = 1'b0;
        end
    end

    assign note_valid_d = (note_d != note_q);

    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign locked     = locked_q;
endmodule
